// File: rtl/sakebi_eth_pkg.sv
// Shared Ethernet definitions for the SAKEBI datapath: CRC-32 constants and
// the receive FCS checker state encoding.
package sakebi_eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
  localparam int unsigned ETH_FCS_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } fcs_state_e;

endpackage

// File: rtl/sakebi_crc32_refl_byte.sv
// One byte of reflected IEEE 802.3 CRC-32, eight unrolled LSB-first steps.
// Purely combinational; shared by the receive checker and the transmit generator.
module sakebi_crc32_refl_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_w;

  always_comb begin
    crc_w = crc_i;
    for (int unsigned b = 0; b < 8; b++) begin
      if (crc_w[0] ^ data_i[b]) begin
        crc_w = (crc_w >> 1) ^ CRC32_POLY_REFL;
      end else begin
        crc_w = crc_w >> 1;
      end
    end
    crc_o = crc_w;
  end

endmodule

// File: rtl/sakebi_fcs_checker.sv
// Receive-side Ethernet FCS checker: CRC-32 over the whole frame, strips the
// trailing FCS through a FCS_BYTES-deep delay line and reports frame status.
module sakebi_fcs_checker
  import sakebi_eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FCS_BYTES  = ETH_FCS_BYTES,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_done,
  output logic                  o_fcs_ok,
  output logic                  o_runt,
  output logic                  o_oversize,
  output logic [LEN_WIDTH-1:0]  o_len
);

  localparam logic [LEN_WIDTH-1:0] LEN_SAT  = '1;
  localparam logic [LEN_WIDTH-1:0] RUNT_LEN = LEN_WIDTH'(FCS_BYTES);
  localparam logic [LEN_WIDTH-1:0] MAX_LENL = LEN_WIDTH'(MAX_LEN);

  fcs_state_e                             state_q, state_d;
  logic [LEN_WIDTH-1:0]                   count_q, count_d, count_inc;
  logic [31:0]                            crc_q, crc_d, crc_next;
  logic [FCS_BYTES-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic                  runt_q, runt_d;
  logic                  over_q, over_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;

  sakebi_crc32_refl_byte u_crc (
    .crc_i  (crc_q),
    .data_i (i_data),
    .crc_o  (crc_next)
  );

  assign count_inc = (count_q == LEN_SAT) ? count_q : count_q + LEN_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    crc_d   = crc_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    data_d  = data_q;
    last_d  = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    runt_d  = 1'b0;
    over_d  = 1'b0;
    len_d   = len_q;

    if (i_valid) begin
      // Oldest byte leaves only in STREAM, so the FCS bytes never reach o_data.
      buf_d = {buf_q[FCS_BYTES-2:0], i_data};
      if (state_q == ST_STREAM) begin
        valid_d = 1'b1;
        data_d  = buf_q[FCS_BYTES-1];
      end

      if (i_last) begin
        done_d  = 1'b1;
        last_d  = (state_q == ST_STREAM);
        len_d   = count_inc;
        runt_d  = (count_inc <= RUNT_LEN);
        ok_d    = (count_inc > RUNT_LEN) && (crc_next == CRC32_RESIDUE);
        over_d  = (count_inc > MAX_LENL);
        state_d = ST_IDLE;
        count_d = '0;
        crc_d   = CRC32_INIT;
      end else begin
        count_d = count_inc;
        crc_d   = crc_next;
        unique case (state_q)
          ST_IDLE:   state_d = ST_FILL;
          ST_FILL:   if (count_q == RUNT_LEN - LEN_WIDTH'(1)) state_d = ST_STREAM;
          ST_STREAM: state_d = ST_STREAM;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      crc_q   <= CRC32_INIT;
      buf_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      runt_q  <= 1'b0;
      over_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      crc_q   <= crc_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      runt_q  <= runt_d;
      over_q  <= over_d;
      len_q   <= len_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_last     = last_q;
  assign o_done     = done_q;
  assign o_fcs_ok   = ok_q;
  assign o_runt     = runt_q;
  assign o_oversize = over_q;
  assign o_len      = len_q;

endmodule

// File: tb/tb_sakebi_fcs_checker.sv
// Self-checking bench for sakebi_fcs_checker: frame-level reference model plus
// literal expectations for the directed frames.
module tb_sakebi_fcs_checker;

  localparam int LW   = 12;
  localparam int MAXL = 1518;
  localparam int LSAT = (1 << LW) - 1;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [7:0]    i_data = '0;
  logic          i_last = 1'b0;
  logic          o_valid, o_last, o_done, o_fcs_ok, o_runt, o_oversize;
  logic [7:0]    o_data;
  logic [LW-1:0] o_len;

  int errors = 0;
  int checks = 0;

  sakebi_fcs_checker #(
    .DATA_WIDTH (8),
    .FCS_BYTES  (4),
    .LEN_WIDTH  (LW),
    .MAX_LEN    (MAXL)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_done     (o_done),
    .o_fcs_ok   (o_fcs_ok),
    .o_runt     (o_runt),
    .o_oversize (o_oversize),
    .o_len      (o_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t f, input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ f[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  function automatic bq_t good_frame(input bq_t p);
    bq_t f = p;
    logic [31:0] c = crc32(p, p.size());
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t f;
    for (int i = 0; i < n; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  // Reference model: expected outputs for the cycle after each posedge.
  bq_t           frm;
  logic          exp_valid = 0, exp_last = 0, exp_done = 0;
  logic          exp_ok = 0, exp_runt = 0, exp_over = 0;
  logic [7:0]    exp_data = '0;
  logic [LW-1:0] exp_len = '0;

  initial begin : model
    int n;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        frm.delete();
        exp_valid = 0; exp_last = 0; exp_done = 0;
      end else begin
        exp_valid = 0; exp_last = 0; exp_done = 0;
        if (i_valid) begin
          frm.push_back(i_data);
          if (frm.size() >= 5) begin
            exp_valid = 1;
            exp_data  = frm[frm.size() - 5];
          end
          if (i_last) begin
            n         = frm.size();
            exp_done  = 1;
            exp_last  = exp_valid;
            exp_len   = (n > LSAT) ? LW'(LSAT) : LW'(n);
            exp_runt  = (n <= 4);
            exp_over  = (int'(exp_len) > MAXL);
            exp_ok    = 0;
            if (n > 4)
              exp_ok = (crc32(frm, n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
            frm.delete();
          end
        end
      end
    end
  end

  // Compare process plus capture of DUT results for the literal checks.
  bq_t           cap;
  int            done_cnt = 0, ok_cnt = 0;
  logic          last_ok = 0, last_runt = 0, last_over = 0;
  logic [LW-1:0] last_len = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_done",  o_done,  0);
      chk("rst_data",  o_data,  0);
      chk("rst_len",   o_len,   0);
    end else begin
      chk("valid", o_valid, exp_valid);
      chk("last",  o_last,  exp_last);
      chk("done",  o_done,  exp_done);
      if (exp_valid) chk("data", o_data, exp_data);
      if (exp_done) begin
        chk("fcs_ok",   o_fcs_ok,   exp_ok);
        chk("runt",     o_runt,     exp_runt);
        chk("oversize", o_oversize, exp_over);
        chk("len",      o_len,      exp_len);
      end
      if (o_valid) cap.push_back(o_data);
      if (o_done) begin
        done_cnt++;
        if (o_fcs_ok) ok_cnt++;
        last_ok   = o_fcs_ok;
        last_runt = o_runt;
        last_over = o_oversize;
        last_len  = o_len;
      end
    end
  end

  task automatic send(input bq_t f, input int gap_pct, input bit term);
    for (int i = 0; i < f.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        i_valid = 0;
        i_last  = 1'($urandom_range(1));
        i_data  = 8'($urandom);
      end
      @(negedge clk);
      i_valid = 1;
      i_data  = f[i];
      i_last  = term && (i == f.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 0;
      i_last  = 0;
    end
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    bq_t p9, good, bad, part;
    int d0, k0;
    p9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    good = good_frame(p9);
    chk("model_fcs", {good[12], good[11], good[10], good[9]}, 32'hCBF4_3926);

    repeat (3) @(negedge clk);
    rst_n = 1;
    idle(2);

    // Good "123456789" frame
    cap.delete(); d0 = done_cnt;
    send(good, 0, 1); idle(3);
    chk("good_payload_n", cap.size(), 9);
    for (int i = 0; i < 9; i++) chk("good_payload", cap_at(i), 32'h31 + i);
    chk("good_done_n", done_cnt - d0, 1);
    chk("good_ok", last_ok, 1);
    chk("good_len", last_len, 13);
    chk("good_runt", last_runt, 0);

    // Corrupted last FCS byte
    bad = good; bad[12] = 8'hCA;
    cap.delete();
    send(bad, 0, 1); idle(3);
    chk("bad_payload_n", cap.size(), 9);
    chk("bad_last_byte", cap_at(8), 32'h39);
    chk("bad_ok", last_ok, 0);
    chk("bad_len", last_len, 13);

    // Runts: 3 bytes, 1 byte, 4 bytes
    cap.delete(); d0 = done_cnt;
    send('{8'hAA, 8'hBB, 8'hCC}, 0, 1); idle(3);
    chk("runt3_payload_n", cap.size(), 0);
    chk("runt3_done_n", done_cnt - d0, 1);
    chk("runt3_runt", last_runt, 1);
    chk("runt3_ok", last_ok, 0);
    chk("runt3_len", last_len, 3);
    send('{8'h55}, 0, 1); idle(3);
    chk("runt1_runt", last_runt, 1);
    chk("runt1_len", last_len, 1);
    send('{8'h01, 8'h02, 8'h03, 8'h04}, 0, 1); idle(3);
    chk("runt4_runt", last_runt, 1);
    chk("runt4_payload_n", cap.size(), 0);

    // Smallest non-runt: one payload byte
    cap.delete();
    send(good_frame('{8'h77}), 0, 1); idle(3);
    chk("min_payload", cap_at(0), 32'h77);
    chk("min_payload_n", cap.size(), 1);
    chk("min_ok", last_ok, 1);
    chk("min_runt", last_runt, 0);

    // Back-to-back, second frame with input gaps and stray i_last
    d0 = done_cnt; k0 = ok_cnt;
    send(good, 0, 1);
    send(good_frame(rand_bytes(20)), 35, 1);
    idle(3);
    chk("b2b_done_n", done_cnt - d0, 2);
    chk("b2b_ok_n", ok_cnt - k0, 2);

    // Length boundaries around MAX_LEN
    send(good_frame(rand_bytes(MAXL - 4)), 0, 1); idle(3);
    chk("max_over", last_over, 0);
    chk("max_len", last_len, MAXL);
    send(good_frame(rand_bytes(MAXL - 3)), 0, 1); idle(3);
    chk("over_over", last_over, 1);
    chk("over_ok", last_ok, 1);
    chk("over_len", last_len, MAXL + 1);

    // Length counter saturation
    send(good_frame(rand_bytes(LSAT + 100)), 0, 1); idle(3);
    chk("sat_len", last_len, LSAT);
    chk("sat_ok", last_ok, 1);

    // Reset mid-frame after 6 bytes, then a clean frame
    part = good[0:5];
    d0 = done_cnt;
    send(part, 0, 0);
    @(negedge clk); i_valid = 0; #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    idle(3);
    chk("abort_no_done", done_cnt - d0, 0);
    cap.delete();
    send(good, 0, 1); idle(3);
    chk("post_rst_done_n", done_cnt - d0, 1);
    chk("post_rst_ok", last_ok, 1);
    chk("post_rst_payload_n", cap.size(), 9);
    chk("post_rst_first", cap_at(0), 32'h31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
